// File: rtl/cam_pkg.sv
// Shared constants, state codes and pixel field layout for the camera capture path.
// Also carries the RGB565 -> RGB444 reduction used by the recognition side.
package cam_pkg;

  localparam int H_PIX_DEF = 640;
  localparam int V_PIX_DEF = 480;
  localparam int FB_WORDS  = 307200;

  typedef logic [1:0] cam_state_t;

  localparam cam_state_t IDLE       = 2'd0;
  localparam cam_state_t SKIP       = 2'd1;
  localparam cam_state_t WAIT_FRAME = 2'd2;
  localparam cam_state_t CAPTURE    = 2'd3;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  function automatic logic [11:0] rgb565_to_444(input logic [15:0] p);
    return {p[R_MSB -: 4], p[G_MSB -: 4], p[B_MSB -: 4]};
  endfunction

endpackage

// File: rtl/cam_capture_byte_pair.sv
// Pairs DVP bytes into 16-bit pixels, high byte first.
// An odd trailing byte is dropped when href falls.
module cam_byte_pair
  import cam_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        href,
  input  logic [7:0]  data,
  output logic        pix_valid,
  output logic [15:0] pix
);

  logic       phase;
  logic [7:0] hi;

  // Track byte phase; emit a pixel on every second byte of a line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= 1'b0;
      hi        <= '0;
      pix_valid <= 1'b0;
      pix       <= '0;
    end else begin
      pix_valid <= 1'b0;
      if (!en || !href) begin
        phase <= 1'b0;
      end else if (!phase) begin
        hi    <= data;
        phase <= 1'b1;
      end else begin
        pix       <= {hi, data};
        pix_valid <= 1'b1;
        phase     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cam_capture.sv
// DVP capture into frame-buffer write port (w_en/addr_w/dat_w on clk_w).
// Optional single-frame snapshot mode: define CAM_SNAPSHOT_EN.
module cam_capture
  import cam_pkg::*;
#(
  parameter int H_PIX       = H_PIX_DEF,
  parameter int V_PIX       = V_PIX_DEF,
  parameter int SKIP_FRAMES = 10,
  parameter int ADDR_W      = 19
) (
  input  logic              clk_w,
  input  logic              rst_n,
  input  logic              cap_en,
`ifdef CAM_SNAPSHOT_EN
  input  logic              snap_req,
`endif
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              w_en,
  output logic [ADDR_W-1:0] addr_w,
  output logic [15:0]       dat_w,
  output logic              frame_done,
  output logic              busy
);

  localparam int XW = $clog2(H_PIX + 1);
  localparam int SW = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);

  localparam logic [XW-1:0]   X_MAX   = XW'(H_PIX);
  localparam logic [SW-1:0]   S_MAX   = SW'(SKIP_FRAMES);
  localparam logic [ADDR_W:0] FB_SZ   = (ADDR_W + 1)'(H_PIX * V_PIX);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIX);

  logic vs_d1, vs_d2;
  logic hr_d1, hr_d2;
  logic [7:0] dat_d1;

  cam_state_t state, state_n;
  logic [SW-1:0]     skip_cnt;
  logic [XW-1:0]     x_cnt;
  logic [ADDR_W-1:0] line_base;

  logic        pix_valid;
  logic [15:0] pix;

  logic vs_rise, vs_fall, hr_fall;
  logic capturing, line_ok, do_wr, start;

  assign vs_rise   = vs_d1 & ~vs_d2;
  assign vs_fall   = ~vs_d1 & vs_d2;
  assign hr_fall   = ~hr_d1 & hr_d2;
  assign capturing = (state == CAPTURE);
  assign line_ok   = ({1'b0, line_base} < FB_SZ);
  assign do_wr     = capturing & pix_valid & (x_cnt < X_MAX) & line_ok;
  assign busy      = (state == WAIT_FRAME) | (state == CAPTURE);

`ifdef CAM_SNAPSHOT_EN
  logic sn_d1, sn_d2;

  // Register the snapshot request so only a clean rising edge arms a frame.
  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      sn_d1 <= 1'b0;
      sn_d2 <= 1'b0;
    end else begin
      sn_d1 <= snap_req;
      sn_d2 <= sn_d1;
    end
  end

  assign start = cap_en & sn_d1 & ~sn_d2;
`else
  assign start = cap_en;
`endif

  // Sample the DVP bus once, keep a second copy for edge detection.
  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      vs_d1  <= 1'b0;
      vs_d2  <= 1'b0;
      hr_d1  <= 1'b0;
      hr_d2  <= 1'b0;
      dat_d1 <= '0;
    end else begin
      vs_d1  <= cam_vsync;
      vs_d2  <= vs_d1;
      hr_d1  <= cam_href;
      hr_d2  <= hr_d1;
      dat_d1 <= cam_data;
    end
  end

  cam_byte_pair u_pair (
    .clk       (clk_w),
    .rst_n     (rst_n),
    .en        (capturing),
    .href      (hr_d1),
    .data      (dat_d1),
    .pix_valid (pix_valid),
    .pix       (pix)
  );

  // Next-state: settle, wait for frame start, capture one frame.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_n = (SKIP_FRAMES == 0) ? WAIT_FRAME : SKIP;
      end
      SKIP: begin
        if (!cap_en)
          state_n = IDLE;
        else if (skip_cnt == S_MAX)
          state_n = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (!cap_en)
          state_n = IDLE;
        else if (vs_fall)
          state_n = CAPTURE;
      end
      CAPTURE: begin
        if (vs_rise) begin
`ifdef CAM_SNAPSHOT_EN
          state_n = IDLE;
`else
          state_n = cap_en ? WAIT_FRAME : IDLE;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Count vsync rising edges while the sensor settles.
  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n)
      skip_cnt <= '0;
    else if (state == IDLE)
      skip_cnt <= '0;
    else if (state == SKIP && vs_rise && skip_cnt != S_MAX)
      skip_cnt <= skip_cnt + 1'b1;
  end

  // Pixel column and line base; a write uses the values before any update.
  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt     <= '0;
      line_base <= '0;
    end else if (state == WAIT_FRAME && vs_fall) begin
      x_cnt     <= '0;
      line_base <= '0;
    end else if (capturing) begin
      if (hr_fall) begin
        x_cnt <= '0;
        if (line_ok)
          line_base <= line_base + H_STEP;
      end else if (pix_valid && x_cnt != X_MAX) begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  // Write port and end-of-frame pulse; address/data hold between writes.
  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      w_en       <= 1'b0;
      addr_w     <= '0;
      dat_w      <= '0;
      frame_done <= 1'b0;
    end else begin
      w_en       <= do_wr;
      frame_done <= capturing & vs_rise;
      if (do_wr) begin
        addr_w <= line_base + ADDR_W'(x_cnt);
        dat_w  <= pix;
      end
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Randomized bench for cam_capture against a frame-level write model.
// Small geometry: 4x2 pixels, two settling frames.
module tb_cam_capture;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int SK = 2;
  localparam int AW = 8;

  logic          clk_w = 1'b0;
  logic          rst_n;
  logic          cap_en;
  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_data;
  logic          w_en;
  logic [AW-1:0] addr_w;
  logic [15:0]   dat_w;
  logic          frame_done;
  logic          busy;
`ifdef CAM_SNAPSHOT_EN
  logic          snap_req = 1'b0;
`endif

  cam_capture #(
    .H_PIX       (H),
    .V_PIX       (V),
    .SKIP_FRAMES (SK),
    .ADDR_W      (AW)
  ) dut (
    .clk_w      (clk_w),
    .rst_n      (rst_n),
    .cap_en     (cap_en),
`ifdef CAM_SNAPSHOT_EN
    .snap_req   (snap_req),
`endif
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .w_en       (w_en),
    .addr_w     (addr_w),
    .dat_w      (dat_w),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk_w = ~clk_w;

  int cyc = 0;
  always @(posedge clk_w) cyc++;

  typedef struct {
    int addr;
    int data;
    int t;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk = 0;
  int  n_err = 0;
  int  n_done = 0;
  int  exp_done = 0;
  bit  en_m;
  int  skip_left;
  int  lens[8];
  bit  force_abcd;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  always @(negedge clk_w) begin : mon
    wr_t e;
    if (rst_n) begin
      if (frame_done) n_done++;
      if (w_en) begin
        if (exp_q.size() == 0) begin
          check("spurious_wen", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("addr", int'(addr_w), e.addr);
          check("data", int'(dat_w), e.data);
          check("latency", cyc, e.t);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_w);
  endtask

  task automatic do_frame(input int nl, input int rst_line,
                          input int drop_line);
    bit capf;
    logic [7:0] hi;
    logic [7:0] lo;
    @(negedge clk_w);
    cam_vsync = 1'b0;
    capf = en_m && skip_left == 0;
    tick(2);
    for (int l = 0; l < nl; l++) begin
      if (l == rst_line) begin
        @(negedge clk_w);
        rst_n = 1'b0;
        #1;
        check("rst_wen", int'(w_en), 0);
        check("rst_addr", int'(addr_w), 0);
        check("rst_dat", int'(dat_w), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk_w);
        rst_n = 1'b1;
        exp_q.delete();
        capf = 1'b0;
        skip_left = SK;
        tick(2);
      end
      if (l == drop_line) begin
        cap_en = 1'b0;
        en_m = 1'b0;
      end
      for (int b = 0; b < lens[l]; b++) begin
        @(negedge clk_w);
        cam_href = 1'b1;
        cam_data = 8'($urandom);
        if (force_abcd && l == 0 && b < 2)
          cam_data = (b == 0) ? 8'hAB : 8'hCD;
        if (b % 2 == 0) begin
          hi = cam_data;
        end else begin
          lo = cam_data;
          if (capf && l < V && b / 2 < H)
            exp_q.push_back('{l * H + b / 2, int'({hi, lo}), cyc + 3});
        end
      end
      @(negedge clk_w);
      cam_href = 1'b0;
      tick(3);
    end
    @(negedge clk_w);
    cam_vsync = 1'b1;
    if (capf)
      exp_done++;
    else if (en_m && skip_left > 0)
      skip_left--;
    tick(4);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    cap_en    = 1'b0;
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    cam_data  = '0;
    force_abcd = 1'b0;
    en_m      = 1'b0;
    skip_left = SK;
    tick(3);
    check("reset_wen", int'(w_en), 0);
    check("reset_addr", int'(addr_w), 0);
    check("reset_dat", int'(dat_w), 0);
    check("reset_done", int'(frame_done), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick(3);
    cap_en = 1'b1;
    en_m = 1'b1;
    skip_left = SK;
    tick(4);
    check("idle_to_skip_busy", int'(busy), 0);

    for (int f = 0; f < 2; f++) begin
      lens[0] = 8;
      lens[1] = 8;
      do_frame(2, -1, -1);
    end
    check("skip_frames_done", n_done, 0);
    check("wait_busy", int'(busy), 1);

    force_abcd = 1'b1;
    do_frame(2, -1, -1);
    force_abcd = 1'b0;
    check("frame3_done", n_done, 1);

    lens[0] = 7;
    lens[1] = 8;
    do_frame(2, -1, -1);

    for (int l = 0; l < 5; l++) lens[l] = 12;
    do_frame(5, -1, -1);

    for (int l = 0; l < 3; l++) lens[l] = 8;
    do_frame(3, 1, -1);
    do_frame(2, -1, -1);
    do_frame(2, -1, -1);
    do_frame(2, -1, -1);

    do_frame(2, -1, 1);
    check("drop_busy", int'(busy), 0);
    do_frame(2, -1, -1);
    cap_en = 1'b1;
    en_m = 1'b1;
    skip_left = SK;
    tick(4);

    for (int f = 0; f < 12; f++) begin
      int nl;
      nl = $urandom_range(0, 4);
      for (int l = 0; l < 8; l++) lens[l] = $urandom_range(0, 13);
      do_frame(nl, -1, -1);
    end

    tick(6);
    check("pending_writes", exp_q.size(), 0);
    check("frame_done_cnt", n_done, exp_done);
    check("busy_end", int'(busy), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
